// File: rtl/usb_tx_sequencer.sv
// USB transmit sequencer: token, DATA and handshake packets with on-the-fly CRC5/CRC16,
// emitted as byte beats over a valid/ready stream to the bit-stuffer/NRZI serializer.
module usb_tx_sequencer #(
  parameter int unsigned MAX_BYTES  = 64,
  parameter int unsigned GAP_CYCLES = 2,
  parameter logic [7:0]  SYNC_BYTE  = 8'h80
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [1:0]                     mode,
  input  logic [3:0]                     token_pid,
  input  logic [6:0]                     addr,
  input  logic [3:0]                     endp,
  input  logic [3:0]                     data_pid,
  input  logic [3:0]                     hs_pid,
  input  logic [$clog2(MAX_BYTES+1)-1:0] byte_count,
  input  logic                           abort,
  input  logic [7:0]                     pay_data,
  input  logic                           pay_valid,
  output logic                           pay_ready,
  output logic [7:0]                     tx_byte,
  output logic                           tx_eop,
  output logic                           tx_valid,
  input  logic                           tx_ready,
  output logic                           busy,
  output logic                           done,
  output logic                           aborted
);

  localparam int CW = $clog2(MAX_BYTES + 1);
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_SYNC, S_PID, S_TOK0, S_TOK1, S_DATA,
    S_CRC_LO, S_CRC_HI, S_EOP, S_GAP, S_DONE
  } state_e;

  typedef enum logic [1:0] {PH_TOKEN, PH_DATA, PH_HS} phase_e;

  state_e         state_q, state_d;
  phase_e         phase_q, phase_d;
  logic [1:0]     mode_q, mode_d;
  logic [3:0]     token_pid_q, token_pid_d;
  logic [6:0]     addr_q, addr_d;
  logic [3:0]     endp_q, endp_d;
  logic [3:0]     data_pid_q, data_pid_d;
  logic [3:0]     hs_pid_q, hs_pid_d;
  logic [CW-1:0]  count_q, count_d;
  logic [CW-1:0]  rem_q, rem_d;
  logic [GW-1:0]  gap_q, gap_d;
  logic [15:0]    crc16_q, crc16_d;
  logic           abort_pend_q, abort_pend_d;
  logic           aborted_q, aborted_d;

  logic           tx_valid_o, tx_eop_o, pay_ready_o;
  logic [7:0]     tx_byte_o;
  logic [3:0]     pid_sel;
  logic [4:0]     crc5_w;
  logic           fire, pay_fire, abort_hit, leave_gap, has_next;
  phase_e         next_phase;

  function automatic logic [4:0] crc5_calc(input logic [10:0] bits);
    logic [4:0] c;
    c = 5'h1F;
    for (int i = 0; i < 11; i++) begin
      if (c[0] ^ bits[i]) c = (c >> 1) ^ 5'h14;
      else                c = c >> 1;
    end
    return c;
  endfunction

  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] d);
    logic [15:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ d[i]) c = (c >> 1) ^ 16'hA001;
      else             c = c >> 1;
    end
    return c;
  endfunction

  // addr goes out first, so it occupies the low bits of the LSB-first bit stream
  assign crc5_w = crc5_calc({endp_q, addr_q});

  always_comb begin
    case (phase_q)
      PH_TOKEN: pid_sel = token_pid_q;
      PH_DATA:  pid_sel = data_pid_q;
      default:  pid_sel = hs_pid_q;
    endcase
  end

  always_comb begin
    has_next   = 1'b0;
    next_phase = PH_HS;
    case (phase_q)
      PH_TOKEN: begin
        has_next   = mode_q[0];
        next_phase = PH_DATA;
      end
      PH_DATA:  has_next = mode_q[1];
      default:  has_next = 1'b0;
    endcase
  end

  always_comb begin
    tx_valid_o  = 1'b0;
    tx_eop_o    = 1'b0;
    tx_byte_o   = 8'h00;
    pay_ready_o = 1'b0;
    case (state_q)
      S_SYNC: begin
        tx_valid_o = 1'b1;
        tx_byte_o  = SYNC_BYTE;
      end
      S_PID: begin
        tx_valid_o = 1'b1;
        tx_byte_o  = {~pid_sel, pid_sel};
      end
      S_TOK0: begin
        tx_valid_o = 1'b1;
        tx_byte_o  = {endp_q[0], addr_q};
      end
      S_TOK1: begin
        tx_valid_o = 1'b1;
        tx_byte_o  = {~crc5_w, endp_q[3:1]};
      end
      S_DATA: begin
        tx_valid_o  = pay_valid;
        tx_byte_o   = pay_data;
        pay_ready_o = tx_ready;
      end
      S_CRC_LO: begin
        tx_valid_o = 1'b1;
        tx_byte_o  = ~crc16_q[7:0];
      end
      S_CRC_HI: begin
        tx_valid_o = 1'b1;
        tx_byte_o  = ~crc16_q[15:8];
      end
      S_EOP: begin
        tx_valid_o = 1'b1;
        tx_eop_o   = 1'b1;
      end
      default: ;
    endcase
  end

  assign fire      = tx_valid_o && tx_ready;
  assign pay_fire  = (state_q == S_DATA) && pay_valid && tx_ready;
  assign abort_hit = abort || abort_pend_q;

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    mode_d       = mode_q;
    token_pid_d  = token_pid_q;
    addr_d       = addr_q;
    endp_d       = endp_q;
    data_pid_d   = data_pid_q;
    hs_pid_d     = hs_pid_q;
    count_d      = count_q;
    rem_d        = rem_q;
    gap_d        = gap_q;
    crc16_d      = crc16_q;
    abort_pend_d = abort_pend_q;
    aborted_d    = aborted_q;
    leave_gap    = 1'b0;

    if (abort && (state_q inside {S_SYNC, S_PID, S_TOK0, S_TOK1, S_DATA, S_CRC_LO, S_CRC_HI}))
      abort_pend_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d       = mode;
          token_pid_d  = token_pid;
          addr_d       = addr;
          endp_d       = endp;
          data_pid_d   = data_pid;
          hs_pid_d     = hs_pid;
          count_d      = (byte_count > CW'(MAX_BYTES)) ? CW'(MAX_BYTES) : byte_count;
          phase_d      = (mode == 2'b10) ? PH_HS : PH_TOKEN;
          abort_pend_d = 1'b0;
          aborted_d    = 1'b0;
          state_d      = S_SYNC;
        end
      end
      S_SYNC: begin
        crc16_d = 16'hFFFF;
        if (fire) begin
          rem_d   = count_q;
          state_d = abort_hit ? S_EOP : S_PID;
        end
      end
      S_PID: begin
        if (fire) begin
          if (abort_hit) state_d = S_EOP;
          else begin
            case (phase_q)
              PH_TOKEN: state_d = S_TOK0;
              PH_DATA:  state_d = (count_q == '0) ? S_CRC_LO : S_DATA;
              default:  state_d = S_EOP;
            endcase
          end
        end
      end
      S_TOK0:   if (fire) state_d = abort_hit ? S_EOP : S_TOK1;
      S_TOK1:   if (fire) state_d = S_EOP;
      S_DATA: begin
        if (pay_fire) begin
          crc16_d = crc16_byte(crc16_q, pay_data);
          rem_d   = rem_q - CW'(1);
          if (abort_hit)              state_d = S_EOP;
          else if (rem_q == CW'(1))   state_d = S_CRC_LO;
        end else if (abort_pend_q && !pay_valid) begin
          // nothing in flight, so the pending abort can close the packet now
          state_d = S_EOP;
        end
      end
      S_CRC_LO: if (fire) state_d = abort_hit ? S_EOP : S_CRC_HI;
      S_CRC_HI: if (fire) state_d = S_EOP;
      S_EOP: begin
        if (fire) begin
          gap_d = GW'(GAP_CYCLES);
          if (GAP_CYCLES == 0) leave_gap = 1'b1;
          else                 state_d   = S_GAP;
        end
      end
      S_GAP: begin
        gap_d = gap_q - GW'(1);
        if (gap_q == GW'(1)) leave_gap = 1'b1;
      end
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    if (leave_gap) begin
      if (abort_pend_q || !has_next) begin
        state_d   = S_DONE;
        aborted_d = abort_pend_q;
      end else begin
        state_d = S_SYNC;
        phase_d = next_phase;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      phase_q      <= PH_TOKEN;
      mode_q       <= 2'b00;
      token_pid_q  <= 4'h0;
      addr_q       <= 7'h00;
      endp_q       <= 4'h0;
      data_pid_q   <= 4'h0;
      hs_pid_q     <= 4'h0;
      count_q      <= '0;
      rem_q        <= '0;
      gap_q        <= '0;
      crc16_q      <= 16'hFFFF;
      abort_pend_q <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      mode_q       <= mode_d;
      token_pid_q  <= token_pid_d;
      addr_q       <= addr_d;
      endp_q       <= endp_d;
      data_pid_q   <= data_pid_d;
      hs_pid_q     <= hs_pid_d;
      count_q      <= count_d;
      rem_q        <= rem_d;
      gap_q        <= gap_d;
      crc16_q      <= crc16_d;
      abort_pend_q <= abort_pend_d;
      aborted_q    <= aborted_d;
    end
  end

  assign tx_valid  = tx_valid_o;
  assign tx_eop    = tx_eop_o;
  assign tx_byte   = tx_byte_o;
  assign pay_ready = pay_ready_o;
  assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done      = (state_q == S_DONE);
  assign aborted   = aborted_q;

endmodule

// File: tb/tb_usb_tx_sequencer.sv
// Scoreboard bench for usb_tx_sequencer: expected beats are queued at launch and
// popped on every tx_valid&&tx_ready handshake; CRCs come from a bit-serial model.
module tb_usb_tx_sequencer;

  localparam int MAX_BYTES  = 64;
  localparam int GAP_CYCLES = 2;
  localparam int CW         = $clog2(MAX_BYTES + 1);

  logic          clk = 1'b0;
  logic          rst, start, abort, pay_valid, pay_ready;
  logic          tx_eop, tx_valid, tx_ready, busy, done, aborted;
  logic [1:0]    mode;
  logic [3:0]    token_pid, endp, data_pid, hs_pid;
  logic [6:0]    addr;
  logic [CW-1:0] byte_count;
  logic [7:0]    pay_data, tx_byte;

  usb_tx_sequencer #(.MAX_BYTES(MAX_BYTES), .GAP_CYCLES(GAP_CYCLES), .SYNC_BYTE(8'h80)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .token_pid(token_pid),
    .addr(addr), .endp(endp), .data_pid(data_pid), .hs_pid(hs_pid),
    .byte_count(byte_count), .abort(abort), .pay_data(pay_data),
    .pay_valid(pay_valid), .pay_ready(pay_ready), .tx_byte(tx_byte),
    .tx_eop(tx_eop), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done), .aborted(aborted)
  );

  always #5 clk = ~clk;

  int         n_chk = 0, n_err = 0;
  int         cyc = 0, done_cnt = 0, done_cyc = 0, d0 = 0, t0 = 0;
  logic       ab_at_done = 1'b0;
  logic       hs_seen = 1'b0;
  logic [9:0] exp_q[$];
  logic [9:0] exp_beat;
  logic [7:0] pay_q[$];
  logic [7:0] pbytes[$];
  int         pay_cnt = 0, first_pop = 0, last_pop = 0;
  int         stall_after = -1, stall_left = 0, abort_at = -1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    hs_seen = pay_valid && pay_ready;
    if (done) begin
      done_cnt++;
      done_cyc   = cyc;
      ab_at_done = aborted;
    end
    if (tx_valid && tx_ready) begin
      if (exp_q.size() > 0) exp_beat = exp_q.pop_front();
      else                  exp_beat = 10'h3FF;
      chk("beat", {tx_eop, tx_byte}, exp_beat);
    end
  end

  // payload source: pops on handshake, optional stall window and abort on a chosen byte
  initial begin
    pay_valid = 1'b0;
    pay_data  = 8'h00;
    abort     = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (hs_seen && pay_q.size() > 0) begin
        void'(pay_q.pop_front());
        pay_cnt++;
        if (pay_cnt == 1) first_pop = cyc;
        last_pop = cyc;
      end
      if (pay_cnt == stall_after && stall_left > 0) begin
        pay_valid = 1'b0;
        stall_left--;
      end else begin
        pay_valid = (pay_q.size() > 0);
        pay_data  = pay_valid ? pay_q[0] : 8'h00;
      end
      abort = (abort_at == pay_cnt) && pay_valid;
    end
  end

  function automatic logic [4:0] m_crc5(input logic [6:0] a, input logic [3:0] e);
    logic [10:0] s;
    logic [4:0]  r;
    s = {e, a};
    r = 5'h1F;
    for (int i = 0; i < 11; i++)
      r = (s[i] ^ r[0]) ? ({1'b0, r[4:1]} ^ 5'h14) : {1'b0, r[4:1]};
    return r;
  endfunction

  function automatic logic [15:0] m_crc16(input int n);
    logic [15:0] r;
    logic [7:0]  b;
    r = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      b = pbytes[i];
      for (int k = 0; k < 8; k++)
        r = (b[k] ^ r[0]) ? ({1'b0, r[15:1]} ^ 16'hA001) : {1'b0, r[15:1]};
    end
    return r;
  endfunction

  task automatic push(input logic [7:0] b);
    exp_q.push_back({2'b00, b});
  endtask

  task automatic push_eop();
    exp_q.push_back(10'h100);
  endtask

  task automatic exp_token(input logic [3:0] p, input logic [6:0] a, input logic [3:0] e);
    logic [4:0] c;
    c = m_crc5(a, e);
    push(8'h80); push({~p, p}); push({e[0], a}); push({~c, e[3:1]}); push_eop();
  endtask

  task automatic exp_data(input logic [3:0] p, input int n);
    logic [15:0] c;
    c = m_crc16(n);
    push(8'h80); push({~p, p});
    for (int i = 0; i < n; i++) push(pbytes[i]);
    push(~c[7:0]); push(~c[15:8]); push_eop();
  endtask

  task automatic cycle();
    @(posedge clk); #1;
  endtask

  task automatic set_txn(input logic [1:0] m, input logic [3:0] tp, input logic [6:0] a,
                         input logic [3:0] e, input logic [3:0] dp, input logic [3:0] hp,
                         input int bc);
    mode = m; token_pid = tp; addr = a; endp = e; data_pid = dp; hs_pid = hp;
    byte_count = CW'(bc);
  endtask

  task automatic load_pay();
    pay_cnt = 0;
    pay_q   = pbytes;
  endtask

  task automatic launch();
    d0    = done_cnt;
    start = 1'b1;
    cycle();
    start = 1'b0;
    chk("lat_busy", busy, 1);
    chk("lat_valid", tx_valid, 1);
    chk("lat_sync", tx_byte, 8'h80);
    t0 = cyc;
  endtask

  task automatic finish_txn(input int budget, input logic exp_ab);
    for (int i = 0; i < budget && done_cnt == d0; i++) cycle();
    chk("done_seen", done_cnt, d0 + 1);
    chk("aborted_at_done", ab_at_done, exp_ab);
    repeat (3) cycle();
    chk("done_once", done_cnt, d0 + 1);
    chk("beats_left", exp_q.size(), 0);
    chk("busy_idle", busy, 0);
    chk("aborted_held", aborted, exp_ab);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; tx_ready = 1'b1;
    set_txn(2'b00, 4'h0, 7'h00, 4'h0, 4'h0, 4'h0, 0);
    repeat (3) cycle();
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_eop", tx_eop, 0);
    chk("rst_tx_byte", tx_byte, 0);
    chk("rst_pay_ready", pay_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_aborted", aborted, 0);
    rst = 1'b0;
    cycle();

    // token only, literal beats; done lands 7 cycles after the first SYNC cycle
    set_txn(2'b00, 4'hD, 7'h00, 4'h0, 4'h3, 4'h2, 0);
    push(8'h80); push(8'h2D); push(8'h00); push(8'h10); push_eop();
    launch();
    finish_txn(40, 1'b0);
    chk("t1_done_latency", done_cyc - t0, 7);

    // token + zero-length DATA
    set_txn(2'b01, 4'h1, 7'h15, 4'h3, 4'h3, 4'h2, 0);
    exp_token(4'h1, 7'h15, 4'h3);
    push(8'h80); push(8'hC3); push(8'h00); push(8'h00); push_eop();
    launch();
    finish_txn(60, 1'b0);

    // handshake only, serializer back-pressure on the PID beat
    set_txn(2'b10, 4'h1, 7'h00, 4'h0, 4'h3, 4'hA, 0);
    pbytes = '{8'h55};
    load_pay();
    push(8'h80); push(8'h5A); push_eop();
    launch();
    cycle();
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_byte", tx_byte, 8'h5A);
      chk("t4_hold_valid", tx_valid, 1);
      chk("t4_pay_ready", pay_ready, 0);
      cycle();
    end
    tx_ready = 1'b1;
    finish_txn(40, 1'b0);
    chk("t4_no_payload", pay_cnt, 0);
    pay_q.delete();
    repeat (2) cycle();

    // abort on the second payload byte of a full transaction
    set_txn(2'b11, 4'h9, 7'h7F, 4'hF, 4'h3, 4'h2, 4);
    pbytes = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    load_pay();
    abort_at = 1;
    exp_token(4'h9, 7'h7F, 4'hF);
    push(8'h80); push(8'hC3); push(8'hAA); push(8'hBB); push_eop();
    launch();
    finish_txn(80, 1'b1);
    chk("t5_pay_taken", pay_cnt, 2);
    abort_at = -1;
    pay_q.delete();
    repeat (2) cycle();

    // full transaction with a 3-cycle payload stall after two bytes
    set_txn(2'b11, 4'h9, 7'h3A, 4'hA, 4'hB, 4'h2, 4);
    pbytes = '{8'h01, 8'h02, 8'h03, 8'h04};
    load_pay();
    stall_after = 2; stall_left = 3;
    exp_token(4'h9, 7'h3A, 4'hA);
    exp_data(4'hB, 4);
    push(8'h80); push(8'hD2); push_eop();
    launch();
    chk("t3_aborted_cleared", aborted, 0);
    finish_txn(120, 1'b0);
    chk("t3_pay_count", pay_cnt, 4);
    chk("t3_pay_span", last_pop - first_pop, 6);
    stall_after = -1;
    repeat (2) cycle();

    // reset in the middle of the payload
    set_txn(2'b01, 4'h1, 7'h01, 4'h1, 4'h3, 4'h2, 5);
    pbytes = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
    load_pay();
    exp_token(4'h1, 7'h01, 4'h1);
    push(8'h80); push(8'hC3);
    for (int i = 0; i < 5; i++) push(pbytes[i]);
    launch();
    for (int i = 0; i < 60 && pay_cnt < 2; i++) cycle();
    chk("t6_reached_data", pay_cnt >= 2, 1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    exp_q.delete();
    pay_q.delete();
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_valid", tx_valid, 0);
    chk("t6_rst_pay_ready", pay_ready, 0);
    repeat (3) cycle();
    chk("t6_no_done", done_cnt, d0);

    set_txn(2'b00, 4'h9, 7'h2B, 4'h5, 4'h3, 4'h2, 0);
    exp_token(4'h9, 7'h2B, 4'h5);
    launch();
    finish_txn(40, 1'b0);

    // oversized byte_count is clamped to MAX_BYTES
    pbytes.delete();
    for (int i = 0; i < 70; i++) pbytes.push_back(8'($urandom_range(0, 255)));
    set_txn(2'b01, 4'h1, 7'h44, 4'h6, 4'hB, 4'h2, 100);
    load_pay();
    exp_token(4'h1, 7'h44, 4'h6);
    exp_data(4'hB, MAX_BYTES);
    launch();
    finish_txn(400, 1'b0);
    chk("t6_clamp", pay_cnt, MAX_BYTES);
    pay_q.delete();
    repeat (2) cycle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
